// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder
//   Recovers hex digits from a multiplexed, active-low seven-segment bus. Each
//   synchronized {seg, an} sample must be stable for STABLE_CYCLES consecutive
//   cycles before it is decoded and captured into the per-digit registers.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   seg_n_i      segment bus, active-low, bit7=a .. bit1=g, bit0=dp
//   an_n_i       digit enables, active-low, bit i selects digit i
//   digit_val_o  last legal value per digit, digit i at [4i+3:4i]
//   digit_vld_o  digit i holds a legal decode
//   digit_dp_o   decimal point lit at the last legal capture of digit i
//   upd_valid_o  one-cycle strobe on a legal capture
//   upd_idx_o    digit index of the last legal capture
//   upd_val_o    decoded value of the last legal capture
//   err_pulse_o  one-cycle strobe on an illegal capture
//   err_count_o  saturating illegal-capture count
//
// Build option
//   SEG_PATTERN_DECODER_ERRCNT_EN: when defined, err_count_o counts illegal
//   captures (saturating at 255, cleared only by reset); otherwise tied to 0.

module seg_pattern_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [7:0]                seg_n_i,
    input  logic [NUM_DIGITS-1:0]     an_n_i,
    output logic [4*NUM_DIGITS-1:0]   digit_val_o,
    output logic [NUM_DIGITS-1:0]     digit_vld_o,
    output logic [NUM_DIGITS-1:0]     digit_dp_o,
    output logic                      upd_valid_o,
    output logic [$clog2(NUM_DIGITS)-1:0] upd_idx_o,
    output logic [3:0]                upd_val_o,
    output logic                      err_pulse_o,
    output logic [7:0]                err_count_o
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] One = NUM_DIGITS'(1);

    typedef enum logic [1:0] {StIdle, StTrack, StHold} state_e;

    // Two-flop synchronizer; resets to "blank, no digit selected".
    logic [7:0]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

    state_e                state_q, state_d;
    logic [7:0]            prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0] prev_an_q, prev_an_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [4*NUM_DIGITS-1:0] digit_val_q, digit_val_d;
    logic [NUM_DIGITS-1:0]   digit_vld_q, digit_vld_d;
    logic [NUM_DIGITS-1:0]   digit_dp_q, digit_dp_d;
    logic                    upd_valid_q, upd_valid_d;
    logic [IdxW-1:0]         upd_idx_q, upd_idx_d;
    logic [3:0]              upd_val_q, upd_val_d;
    logic                    err_pulse_q, err_pulse_d;

    logic [NUM_DIGITS-1:0] an_en;
    logic                  addressable;
    logic                  same;
    logic                  capture;
    logic [3:0]            dec_val;
    logic                  dec_legal;
    logic [IdxW-1:0]       cap_idx;

    // Exactly one enable low: non-zero and power of two.
    assign an_en       = ~an_s2_q;
    assign addressable = (an_en != '0) && ((an_en & (an_en - One)) == '0);
    assign same        = (seg_s2_q == prev_seg_q) && (an_s2_q == prev_an_q);

    always_comb begin
        state_d    = state_q;
        prev_seg_d = prev_seg_q;
        prev_an_d  = prev_an_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (addressable) begin
                    state_d    = StTrack;
                    prev_seg_d = seg_s2_q;
                    prev_an_d  = an_s2_q;
                end
            end
            StTrack: begin
                if (!addressable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!same) begin
                    prev_seg_d = seg_s2_q;
                    prev_an_d  = an_s2_q;
                    cnt_d      = '0;
                end else if (cnt_q == CntMax) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (!same) begin
                    cnt_d = '0;
                    if (addressable) begin
                        state_d    = StTrack;
                        prev_seg_d = seg_s2_q;
                        prev_an_d  = an_s2_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode on segments a..g only; dp never affects legality.
    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        case (prev_seg_q[7:1])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        cap_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!prev_an_q[i]) cap_idx = IdxW'(i);
        end
    end

    always_comb begin
        digit_val_d = digit_val_q;
        digit_vld_d = digit_vld_q;
        digit_dp_d  = digit_dp_q;
        upd_valid_d = 1'b0;
        upd_idx_d   = upd_idx_q;
        upd_val_d   = upd_val_q;
        err_pulse_d = 1'b0;
        if (capture) begin
            if (dec_legal) begin
                digit_val_d[{cap_idx, 2'b00} +: 4] = dec_val;
                digit_vld_d[cap_idx]               = 1'b1;
                digit_dp_d[cap_idx]                = ~prev_seg_q[0];
                upd_valid_d                        = 1'b1;
                upd_idx_d                          = cap_idx;
                upd_val_d                          = dec_val;
            end else begin
                digit_vld_d[cap_idx] = 1'b0;
                err_pulse_d          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_s1_q    <= '1;
            seg_s2_q    <= '1;
            an_s1_q     <= '1;
            an_s2_q     <= '1;
            state_q     <= StIdle;
            prev_seg_q  <= '0;
            prev_an_q   <= '0;
            cnt_q       <= '0;
            digit_val_q <= '0;
            digit_vld_q <= '0;
            digit_dp_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_val_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            seg_s1_q    <= seg_n_i;
            seg_s2_q    <= seg_s1_q;
            an_s1_q     <= an_n_i;
            an_s2_q     <= an_s1_q;
            state_q     <= state_d;
            prev_seg_q  <= prev_seg_d;
            prev_an_q   <= prev_an_d;
            cnt_q       <= cnt_d;
            digit_val_q <= digit_val_d;
            digit_vld_q <= digit_vld_d;
            digit_dp_q  <= digit_dp_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_val_q   <= upd_val_d;
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef SEG_PATTERN_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_pulse_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = '0;
`endif

    assign digit_val_o = digit_val_q;
    assign digit_vld_o = digit_vld_q;
    assign digit_dp_o  = digit_dp_q;
    assign upd_valid_o = upd_valid_q;
    assign upd_idx_o   = upd_idx_q;
    assign upd_val_o   = upd_val_q;
    assign err_pulse_o = err_pulse_q;

endmodule
